// File: rtl/rgb_descrambler_stream_if.sv
`default_nettype none
// ============================================================================
// Module  : rgb_descrambler_stream_if
// Brief   : Valid/ready pixel stream bundle (input side and output side).
// Revision: 1.0 - initial release
// ============================================================================
interface rgb_descrambler_stream_if #(
    parameter int CH_W = 4
);
    logic                in_valid;
    logic                in_ready;
    logic                in_sof;
    logic [3*CH_W-1:0]   in_rgb;
    logic                out_valid;
    logic                out_ready;
    logic                out_sof;
    logic [3*CH_W-1:0]   out_rgb;
    logic [2:0]          lost_mask;

    modport slave (
        input  in_valid, in_sof, in_rgb, out_ready,
        output in_ready, out_valid, out_sof, out_rgb, lost_mask
    );

    modport master (
        output in_valid, in_sof, in_rgb, out_ready,
        input  in_ready, out_valid, out_sof, out_rgb, lost_mask
    );
endinterface
`default_nettype wire

// File: rtl/rgb_descrambler_stream.sv
`default_nettype none
// ============================================================================
// Module  : rgb_descrambler_stream
// Brief   : 2-stage streaming inverse of the RGB channel scrambler.
// Revision: 1.0 - initial release
// ============================================================================
module rgb_descrambler_stream #(
    parameter int         CH_W          = 4,
    parameter logic [5:0] RESET_CONTROL = 6'b00_01_10
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [5:0]        control_in,
    input  wire logic              control_load,
    output logic      [5:0]        active_control,
    rgb_descrambler_stream_if.slave bus
);
    localparam int c_PIX_W = 3 * CH_W;

    logic               w_adv;
    logic               w_accept;
    logic               w_sof_accept;
    logic [5:0]         w_applied;
    logic [c_PIX_W-1:0] w_raw;
    logic [2:0]         w_lost;

    logic [5:0]         r_active;
    logic [5:0]         r_pending;
    logic               r_pending_valid;
    logic               r_s1_valid;
    logic               r_s1_sof;
    logic [c_PIX_W-1:0] r_s1_rgb;
    logic [5:0]         r_s1_ctrl;
    logic               r_s2_valid;
    logic               r_out_sof;
    logic [c_PIX_W-1:0] r_out_rgb;
    logic [2:0]         r_lost;

    always_comb begin
        w_adv        = ~r_s2_valid | bus.out_ready;
        w_accept     = bus.in_valid & w_adv;
        w_sof_accept = w_accept & bus.in_sof;
        // A load coinciding with an accepted sof beat bypasses the pending slot.
        if (w_sof_accept && control_load)
            w_applied = control_in;
        else if (w_sof_accept && r_pending_valid)
            w_applied = r_pending;
        else
            w_applied = r_active;
    end

    // Raw channel x comes from the first scrambled field (R, then G, then B) coded x.
    always_comb begin
        logic found;
        w_raw  = '0;
        w_lost = '0;
        found  = 1'b0;
        for (int x = 0; x < 3; x++) begin
            found = 1'b0;
            for (int f = 0; f < 3; f++) begin
                if (!found && (r_s1_ctrl[(2-f)*2 +: 2] == 2'(x))) begin
                    found = 1'b1;
                    w_raw[(2-x)*CH_W +: CH_W] = r_s1_rgb[(2-f)*CH_W +: CH_W];
                end
            end
            w_lost[2-x] = ~found;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active        <= RESET_CONTROL;
            r_pending       <= RESET_CONTROL;
            r_pending_valid <= 1'b0;
            r_s1_valid      <= 1'b0;
            r_s1_sof        <= 1'b0;
            r_s1_rgb        <= '0;
            r_s1_ctrl       <= RESET_CONTROL;
            r_s2_valid      <= 1'b0;
            r_out_sof       <= 1'b0;
            r_out_rgb       <= '0;
            r_lost          <= '0;
        end else begin
            if (w_sof_accept && (control_load || r_pending_valid)) begin
                r_active        <= w_applied;
                r_pending_valid <= 1'b0;
            end else if (control_load) begin
                r_pending       <= control_in;
                r_pending_valid <= 1'b1;
            end

            if (w_adv) begin
                r_s1_valid <= w_accept;
                r_s1_sof   <= bus.in_sof;
                r_s1_rgb   <= bus.in_rgb;
                r_s1_ctrl  <= w_applied;
                r_s2_valid <= r_s1_valid;
                r_out_sof  <= r_s1_sof & r_s1_valid;
                r_out_rgb  <= w_raw;
                r_lost     <= w_lost;
            end
        end
    end

    assign bus.in_ready    = w_adv;
    assign bus.out_valid   = r_s2_valid;
    assign bus.out_sof     = r_out_sof;
    assign bus.out_rgb     = r_out_rgb;
    assign bus.lost_mask   = r_lost;
    assign active_control  = r_active;
endmodule
`default_nettype wire

// File: tb/tb_rgb_descrambler_stream.sv
`default_nettype none
// ============================================================================
// Module  : tb_rgb_descrambler_stream
// Brief   : Self-checking bench for rgb_descrambler_stream.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rgb_descrambler_stream;
    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] control_in;
    logic       control_load;
    logic [5:0] active_control;

    always #5 clk = ~clk;

    rgb_descrambler_stream_if #(.CH_W(4)) bus ();

    rgb_descrambler_stream #(.CH_W(4), .RESET_CONTROL(6'b00_01_10)) dut (
        .clk            (clk),
        .rst            (rst),
        .control_in     (control_in),
        .control_load   (control_load),
        .active_control (active_control),
        .bus            (bus)
    );

    typedef struct packed {
        logic [11:0] rgb;
        logic        sof;
        logic [2:0]  lost;
    } exp_t;

    typedef struct {
        logic [5:0]  ctrl;
        logic [11:0] pix;
        logic [11:0] rgb;
        logic [2:0]  lost;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[9];
    int   checks = 0;
    int   errors = 0;
    logic saw_ready_low = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic monitor();
        exp_t        e;
        logic        stall = 1'b0;
        logic [11:0] hr = '0;
        logic        hs = 1'b0;
        logic [2:0]  hl = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("hold_valid", 32'(bus.out_valid), 32'd1);
                    chk("hold_rgb",   32'(bus.out_rgb),   32'(hr));
                    chk("hold_sof",   32'(bus.out_sof),   32'(hs));
                    chk("hold_lost",  32'(bus.lost_mask), 32'(hl));
                end
                if (bus.in_valid && !bus.in_ready) saw_ready_low = 1'b1;
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat actual=%03h required=none", bus.out_rgb);
                    end else begin
                        e = sb.pop_front();
                        chk("out_rgb",   32'(bus.out_rgb),   32'(e.rgb));
                        chk("out_sof",   32'(bus.out_sof),   32'(e.sof));
                        chk("lost_mask", 32'(bus.lost_mask), 32'(e.lost));
                    end
                end
                stall = bus.out_valid && !bus.out_ready;
                hr    = bus.out_rgb;
                hs    = bus.out_sof;
                hl    = bus.lost_mask;
            end
        end
    endtask

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic load(input logic [5:0] c);
        control_in   = c;
        control_load = 1'b1;
        @(posedge clk);
        #1;
        control_load = 1'b0;
    endtask

    task automatic send(input logic [11:0] pix, input logic sof, input logic ld,
                        input logic [5:0] ctl, input logic [11:0] er,
                        input logic [2:0] el, input logic push);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_rgb   = pix;
        bus.in_sof   = sof;
        control_load = ld;
        control_in   = ctl;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=in_ready_low required=accept pix=%03h", pix);
        end else if (push) begin
            sb.push_back('{rgb: er, sof: sof, lost: el});
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        control_load = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0 pending beats", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        vecs[0] = '{6'b000110, 12'hABC, 12'hABC, 3'b000};
        vecs[1] = '{6'b100100, 12'hCBA, 12'hABC, 3'b000};
        vecs[2] = '{6'b111111, 12'h5A3, 12'h000, 3'b111};
        vecs[3] = '{6'b000000, 12'h777, 12'h700, 3'b011};
        vecs[4] = '{6'b011000, 12'h123, 12'h312, 3'b000};
        vecs[5] = '{6'b010101, 12'h9AB, 12'h090, 3'b101};
        vecs[6] = '{6'b110010, 12'hDEF, 12'hE0F, 3'b010};
        vecs[7] = '{6'b101010, 12'h456, 12'h004, 3'b110};
        vecs[8] = '{6'b000100, 12'h8C1, 12'h8C0, 3'b001};

        rst           = 1'b1;
        control_in    = '0;
        control_load  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.in_rgb    = '0;
        bus.out_ready = 1'b1;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid),  32'd0);
        chk("rst_out_sof",   32'(bus.out_sof),    32'd0);
        chk("rst_out_rgb",   32'(bus.out_rgb),    32'd0);
        chk("rst_lost",      32'(bus.lost_mask),  32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),   32'd1);
        chk("rst_active",    32'(active_control), 32'b000110);
        @(posedge clk);
        #1;

        // Mapping table: each entry is its own one-beat frame.
        for (int i = 0; i < 9; i++) begin
            load(vecs[i].ctrl);
            send(vecs[i].pix, 1'b1, 1'b0, 6'd0, vecs[i].rgb, vecs[i].lost, 1'b1);
            chk("active_after_sof", 32'(active_control), 32'(vecs[i].ctrl));
            @(negedge clk);
            chk("latency_t1", 32'(bus.out_valid), 32'd0);
            @(negedge clk);
            chk("latency_t2", 32'(bus.out_valid), 32'd1);
            @(posedge clk);
            #1;
            drain();
        end

        // Frame-boundary staging; active is 000100 coming in.
        send(12'h0F0, 1'b1, 1'b1, 6'b000110, 12'h0F0, 3'b000, 1'b1);
        send(12'h111, 1'b0, 1'b0, 6'd0,      12'h111, 3'b000, 1'b1);
        load(6'b111111);
        send(12'h222, 1'b0, 1'b0, 6'd0,      12'h222, 3'b000, 1'b1);
        chk("active_mid_frame", 32'(active_control), 32'b000110);
        send(12'h333, 1'b1, 1'b0, 6'd0,      12'h000, 3'b111, 1'b1);
        chk("active_new_frame", 32'(active_control), 32'b111111);
        send(12'h444, 1'b0, 1'b0, 6'd0,      12'h000, 3'b111, 1'b1);
        load(6'b000000);
        load(6'b000110);
        send(12'h555, 1'b1, 1'b0, 6'd0,      12'h555, 3'b000, 1'b1);
        chk("active_last_load", 32'(active_control), 32'b000110);
        drain();

        // Backpressure over a continuous 8-beat stream.
        saw_ready_low = 1'b0;
        fork
            begin
                for (int i = 1; i <= 8; i++)
                    send(12'(i), (i == 1), 1'b0, 6'd0, 12'(i), 3'b000, 1'b1);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_in_ready_low", 32'(saw_ready_low), 32'd1);

        // Reset with two beats in flight and a pending control word.
        load(6'b111111);
        bus.out_ready = 1'b0;
        send(12'h9E1, 1'b0, 1'b0, 6'd0, 12'h000, 3'b000, 1'b0);
        send(12'h9E2, 1'b0, 1'b0, 6'd0, 12'h000, 3'b000, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(bus.out_valid),  32'd0);
        chk("mid_rst_active",    32'(active_control), 32'b000110);
        chk("mid_rst_in_ready",  32'(bus.in_ready),   32'd1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send(12'h6A5, 1'b1, 1'b0, 6'd0, 12'h6A5, 3'b000, 1'b1);
        drain();
        chk("post_rst_active", 32'(active_control), 32'b000110);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/rgb_descrambler_stream.md
Name: rgb_descrambler_stream

Overview:
- Streaming inverse of the 12-bit RGB channel scrambler (4 bits per channel, R=[11:8], G=[7:4], B=[3:0]).
- Takes scrambled pixels plus the 6-bit control word that produced them, reconstructs the raw pixel and flags channels that cannot be recovered.
- Sits on the pixel path after the scrambler, or at the far end of a link carrying scrambled frames.
- Valid/ready streaming, 2-stage pipeline; control changes take effect only at frame boundaries.

Parameters:
- CH_W, 4, bits per colour channel; pixel width is 3*CH_W.
- RESET_CONTROL, 6'b00_01_10, active control word after reset (identity mapping).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- control_in  input  6  scrambler control word: [5:4] selects the source of scrambled R, [3:2] of G, [1:0] of B (00=R, 01=G, 10=B, 11=zero).
- control_load  input  1  single-cycle pulse; captures control_in into the pending register.
- in_valid  input  1  input pixel valid.
- in_ready  output  1  block accepts the input beat this cycle.
- in_sof  input  1  first pixel of frame, qualified by in_valid.
- in_rgb  input  12  scrambled pixel.
- out_valid  output  1  output pixel valid.
- out_ready  input  1  downstream accepts.
- out_sof  output  1  start of frame, aligned with out_rgb.
- out_rgb  output  12  reconstructed pixel.
- lost_mask  output  3  [2]=R, [1]=G, [0]=B; 1 means the raw channel is absent from the scrambled word and is output as 0.
- active_control  output  6  control word currently applied to incoming beats.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - out_valid=0, out_sof=0, out_rgb=0, lost_mask=0.
  - Both stage valid bits cleared; active_control=RESET_CONTROL; pending_valid=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-stream discards all in-flight beats; nothing is emitted.
- Accept: a beat transfers when in_valid & in_ready. Emit: a beat leaves when out_valid & out_ready.
- Pipeline advance: adv = ~s2_valid | out_ready. Set in_ready = adv, which is combinational from out_ready and registered state only.
- Stage 1: on adv, register the pixel, sof and the control word applied to that beat; s1_valid <= accepted.
- Stage 2: on adv, compute the inverse mapping from the stage-1 registers into out_rgb and lost_mask; s2_valid <= s1_valid.
- Latency: exactly 2 cycles from accept to out_valid when there is no backpressure. Throughput is 1 beat/cycle.
- Control staging:
  - control_load sets pending <= control_in and pending_valid <= 1. A later load before promotion overwrites pending.
  - On an accepted beat with in_sof=1 and pending_valid=1: the pending word is applied to that beat, active_control <= pending, pending_valid <= 0.
  - control_load in the same cycle as an accepted sof beat: control_in is applied to that beat directly and becomes active.
  - Non-sof beats always use active_control.
- Inverse mapping, per raw channel X in {R=00, G=01, B=10}:
  - Search the scrambled fields in priority order R field [5:4], then G field [3:2], then B field [1:0].
  - The first field equal to X supplies raw X from the corresponding scrambled channel.
  - If no field matches: raw X = 0 and lost_mask bit = 1.
  - Code 11 never matches.
- Stall: when out_valid=1 and out_ready=0, out_rgb, out_sof and lost_mask hold stable; no beat is dropped or duplicated; order is preserved.

Test Plan:
- Identity: reset, 0xABC with in_sof=1 -> out_rgb=0xABC, out_sof=1, lost_mask=000 two cycles later; active_control=6'b000110.
- Swap: load 6'b100100, then sof beat 0xCBA -> out_rgb=0xABC, lost_mask=000; active_control=6'b100100 after the accept.
- Drop and duplicate:
  - control 6'b111111, pixel 0x5A3 -> out 0x000, lost_mask=111.
  - control 6'b000000, pixel 0x777 -> out 0x700, lost_mask=011.
- Frame-boundary staging: load 6'b111111 mid-frame -> remaining beats still use the old control; the next sof beat and everything after it is zeroed. Two loads before the sof -> only the last one applies.
- Backpressure: stream 8 beats 0x001..0x008, out_ready low for cycles 3-5 -> in_ready low once both stages are full; output sequence is exactly 0x001..0x008 in order, held stable while stalled.
- Reset mid-stream: rst=1 with 2 beats in flight -> out_valid=0 the following cycle, neither beat emitted, active_control=6'b000110, pending discarded.
